// File: rtl/nn_parameters.sv
// Shared layer constants, FSM state type and output post-processing
// for the speech-recognition dense layers.
package nn_parameters;

    // Default sizes of the first dense layer in the pipeline
    localparam int unsigned IN_SIZE_1  = 16;
    localparam int unsigned OUT_SIZE_1 = 8;

    // Working width of the post-processing function; ACC_W must not exceed it
    localparam int unsigned SAT_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC,
        ACT,
        DONE
    } dense_state_t;

    // Arithmetic shift, optional ReLU, then saturation to an out_w-bit signed range.
    // Callers truncate the result to out_w bits.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int unsigned             shift,
        input logic                    relu,
        input int unsigned             out_w
    );
        logic signed [SAT_W-1:0] y;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        y     = acc >>> shift;
        if (relu && y[SAT_W-1]) begin
            y = '0;
        end
        max_v = $signed({SAT_W{1'b1}} >> (SAT_W - out_w + 1));
        min_v = ~max_v;
        if (y > max_v) begin
            y = max_v;
        end else if (y < min_v) begin
            y = min_v;
        end
        return y;
    endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One output neuron: accumulator loaded with the bias, one MAC per cycle,
// and a registered post-processed output that holds until the next ACT.
module dense_mac_lane
    import nn_parameters::*;
#(
    parameter int unsigned IN_W      = 32,
    parameter int unsigned W_W       = 16,
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned OUT_W     = 48,
    parameter int unsigned OUT_SHIFT = 0,
    parameter int unsigned RELU_EN   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_en,
    input  logic                    mac_en,
    input  logic                    act_en,
    input  logic signed [W_W-1:0]   bias,
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [W_W-1:0]   w,
    output logic signed [OUT_W-1:0] y
);

    logic signed [ACC_W-1:0]     acc;
    logic signed [IN_W+W_W-1:0]  prod;
    logic signed [OUT_W-1:0]     post;

    // Full-width signed product and post-processed accumulator value
    always_comb begin
        prod = (IN_W+W_W)'(x) * (IN_W+W_W)'(w);
        post = OUT_W'(sat_shift(SAT_W'(acc), OUT_SHIFT, RELU_EN != 0, OUT_W));
    end

    // Accumulator (bias load / MAC) and output register (loaded in ACT only)
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            y   <= '0;
        end else begin
            if (init_en) begin
                acc <= ACC_W'(bias);
            end else if (mac_en) begin
                acc <= acc + ACC_W'(prod);
            end
            if (act_en) begin
                y <= post;
            end
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Fully-connected layer with ReLU: captures one input vector, runs OUT_SIZE
// parallel MAC lanes over the inputs one element per cycle, then holds the
// result until the consumer accepts it. Weights and bias are constant ROMs
// given as packed parameter images (weight [i][j] at index i*OUT_SIZE+j).
module dense_layer_seq
    import nn_parameters::*;
#(
    parameter int unsigned IN_SIZE   = IN_SIZE_1,
    parameter int unsigned OUT_SIZE  = OUT_SIZE_1,
    parameter int unsigned IN_W      = 32,
    parameter int unsigned W_W       = 16,
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned OUT_W     = 48,
    parameter int unsigned OUT_SHIFT = 0,
    parameter int unsigned RELU_EN   = 1,
    parameter logic [IN_SIZE*OUT_SIZE*W_W-1:0] W_INIT = '0,
    parameter logic [OUT_SIZE*W_W-1:0]         B_INIT = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_SIZE*IN_W-1:0]   in_vector,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_SIZE*OUT_W-1:0] out_vector,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(IN_SIZE) + 1;
    localparam int unsigned AW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

    dense_state_t state;
    dense_state_t state_nxt;

    logic [IDX_W-1:0]       idx;
    logic [AW-1:0]          idx_a;
    logic                   accept;
    logic                   init_en;
    logic                   mac_en;
    logic                   act_en;
    logic signed [IN_W-1:0] x_reg [IN_SIZE];
    logic signed [IN_W-1:0] x_sel;
    logic signed [W_W-1:0]  w_sel [OUT_SIZE];

    assign idx_a = idx[AW-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state controls; out_valid is exactly "in DONE"
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        init_en   = 1'b0;
        mac_en    = 1'b0;
        act_en    = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid) state_nxt = BIAS;
            end
            BIAS: begin
                init_en   = 1'b1;
                state_nxt = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (idx == IDX_W'(IN_SIZE - 1)) state_nxt = ACT;
            end
            ACT: begin
                act_en    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input capture on accept and element index sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            for (int unsigned i = 0; i < IN_SIZE; i++) begin
                x_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int unsigned i = 0; i < IN_SIZE; i++) begin
                    x_reg[i] <= in_vector[i*IN_W +: IN_W];
                end
            end
            if (init_en) begin
                idx <= '0;
            end else if (mac_en) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Current input element and the matching weight row from the ROM image
    always_comb begin
        x_sel = x_reg[idx_a];
        for (int unsigned j = 0; j < OUT_SIZE; j++) begin
            w_sel[j] = W_INIT[(32'(idx_a) * OUT_SIZE + j) * W_W +: W_W];
        end
    end

    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_lane
        dense_mac_lane #(
            .IN_W      (IN_W),
            .W_W       (W_W),
            .ACC_W     (ACC_W),
            .OUT_W     (OUT_W),
            .OUT_SHIFT (OUT_SHIFT),
            .RELU_EN   (RELU_EN)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .init_en (init_en),
            .mac_en  (mac_en),
            .act_en  (act_en),
            .bias    (B_INIT[j*W_W +: W_W]),
            .x       (x_sel),
            .w       (w_sel[j]),
            .y       (out_vector[j*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Scoreboard bench for dense_layer_seq: four small instances (ReLU, linear,
// saturating, shifted) with directed vectors and hand-computed results.
module tb_dense_layer_seq;

    localparam logic [127:0] W_PM  = {4{16'hFFFF, 16'h0001}};
    localparam logic [31:0]  B_PM  = {16'h0000, 16'h0005};
    localparam logic [127:0] W_MAX = {8{16'h7FFF}};
    localparam logic [31:0]  B_Z   = 32'h0;
    localparam longint       LAT   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst       [4];
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic         busy      [4];
    logic [127:0] in_vec    [4];
    logic [95:0]  ov0, ov1;
    logic [31:0]  ov2, ov3;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        longint y0;
        longint y1;
        longint acc;
    } exp_t;

    exp_t sbq [4][$];
    exp_t cur [4];
    bit   seen[4];
    bit   have[4];

    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(32), .W_W(16), .ACC_W(50), .OUT_W(48),
                      .OUT_SHIFT(0), .RELU_EN(1), .W_INIT(W_PM), .B_INIT(B_PM)) u_relu (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_vector(in_vec[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_vector(ov0), .busy(busy[0]));

    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(32), .W_W(16), .ACC_W(50), .OUT_W(48),
                      .OUT_SHIFT(0), .RELU_EN(0), .W_INIT(W_PM), .B_INIT(B_PM)) u_lin (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_vector(in_vec[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_vector(ov1), .busy(busy[1]));

    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(32), .W_W(16), .ACC_W(50), .OUT_W(16),
                      .OUT_SHIFT(0), .RELU_EN(1), .W_INIT(W_MAX), .B_INIT(B_Z)) u_sat (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_vector(in_vec[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_vector(ov2), .busy(busy[2]));

    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(32), .W_W(16), .ACC_W(50), .OUT_W(16),
                      .OUT_SHIFT(30), .RELU_EN(1), .W_INIT(W_MAX), .B_INIT(B_Z)) u_shift (
        .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_vector(in_vec[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_vector(ov3), .busy(busy[3]));

    function automatic longint get_y(input int k, input int j);
        case (k)
            0:       get_y = longint'($signed(ov0[j*48 +: 48]));
            1:       get_y = longint'($signed(ov1[j*48 +: 48]));
            2:       get_y = longint'($signed(ov2[j*16 +: 16]));
            default: get_y = longint'($signed(ov3[j*16 +: 16]));
        endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Offer one vector to instance k; optionally push its expected result
    task automatic send(input int k, input longint x0, input longint x1, input longint x2,
                        input longint x3, input bit push, input longint e0, input longint e1,
                        output longint acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[k]) begin
            tests++;
            fails++;
            $display("FAIL send_timeout dut%0d: in_ready stayed 0, expected 1", k);
            acc = cyc;
        end else begin
            in_vec[k]   = {x3[31:0], x2[31:0], x1[31:0], x0[31:0]};
            in_valid[k] = 1'b1;
            @(posedge clk);
            #1;
            in_valid[k] = 1'b0;
            in_vec[k]   = {$urandom(), $urandom(), $urandom(), $urandom()};
            acc         = cyc;
            if (push) sbq[k].push_back('{e0, e1, cyc});
        end
    endtask

    // Monitor: pop on each new result, check value and latency; recheck at handshake
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && !seen[k]) begin
                seen[k] = 1'b1;
                if (sbq[k].size() == 0) begin
                    tests++;
                    fails++;
                    have[k] = 1'b0;
                    $display("FAIL unexpected_output dut%0d: got out_valid=1, expected no result", k);
                end else begin
                    cur[k]  = sbq[k].pop_front();
                    have[k] = 1'b1;
                    chk($sformatf("dut%0d_y0", k), get_y(k, 0), cur[k].y0);
                    chk($sformatf("dut%0d_y1", k), get_y(k, 1), cur[k].y1);
                    chk($sformatf("dut%0d_latency", k), cyc - cur[k].acc, LAT);
                end
            end
            if (out_valid[k] && out_ready[k] && have[k]) begin
                chk($sformatf("dut%0d_hs_y0", k), get_y(k, 0), cur[k].y0);
                chk($sformatf("dut%0d_hs_y1", k), get_y(k, 1), cur[k].y1);
            end
            if (!out_valid[k]) begin
                seen[k] = 1'b0;
                have[k] = 1'b0;
            end
        end
    end

    initial begin
        longint a, a1, a2, a3;
        longint snap0, snap1;
        int n, bad;

        for (int k = 0; k < 4; k++) begin
            rst[k]       = 1'b1;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            in_vec[k]    = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;

        // Reset state
        chk("reset_in_ready", longint'(in_ready[0]), 1);
        chk("reset_out_valid", longint'(out_valid[0]), 0);
        chk("reset_busy", longint'(busy[0]), 0);
        chk("reset_out_y0", get_y(0, 0), 0);
        chk("reset_out_y1", get_y(0, 1), 0);

        // ReLU and linear outputs
        send(0, 1, 2, 3, 4, 1'b1, 15, 0, a);
        send(1, 1, 2, 3, 4, 1'b1, 15, -10, a);
        send(1, -1, -2, -3, -4, 1'b1, -5, 10, a);

        // Saturation and shift
        send(2, 32767, 32767, 32767, 32767, 1'b1, 32767, 32767, a);
        send(3, 32767, 32767, 32767, 32767, 1'b1, 3, 3, a);

        // Backpressure: result held, in_ready low, pending in_valid not queued
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        send(0, 2, 4, 6, 8, 1'b1, 25, 0, a);
        n = 0;
        while (!out_valid[0] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid", longint'(out_valid[0]), 1);
        snap0       = get_y(0, 0);
        snap1       = get_y(0, 1);
        in_vec[0]   = {32'd40, 32'd30, 32'd20, 32'd10};
        in_valid[0] = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 ||
                get_y(0, 0) != snap0 || get_y(0, 1) != snap1) bad++;
        end
        chk("bp_hold_bad_cycles", bad, 0);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_in_ready", longint'(in_ready[0]), 1);
        chk("bp_idle_out_valid", longint'(out_valid[0]), 0);
        @(posedge clk);
        #1;
        chk("bp_next_accepted", longint'(busy[0]), 1);
        in_valid[0] = 1'b0;
        sbq[0].push_back('{105, 0, cyc});

        // Reset during MAC at idx=2 aborts the vector
        send(0, 5, 6, 7, 8, 1'b0, 0, 0, a);
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        chk("abort_in_ready", longint'(in_ready[0]), 1);
        chk("abort_out_valid", longint'(out_valid[0]), 0);
        chk("abort_busy", longint'(busy[0]), 0);
        chk("abort_y0", get_y(0, 0), 0);
        chk("abort_y1", get_y(0, 1), 0);
        send(0, 1, 2, 3, 4, 1'b1, 15, 0, a);

        // Back-to-back with out_ready high
        send(0, -1, -2, -3, -4, 1'b1, 0, 10, a1);
        send(0, 100, -50, 7, -60, 1'b1, 2, 3, a2);
        send(0, 2147483647, 2147483647, 2147483647, 2147483647, 1'b1, 64'd8589934593, 0, a3);
        chk("b2b_spacing_1", a2 - a1, 8);
        chk("b2b_spacing_2", a3 - a2, 8);

        // Drain
        n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() != 0 ||
                out_valid[0] || out_valid[1] || out_valid[2] || out_valid[3]) && n < 200) begin
            @(posedge clk);
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain_dut%0d", k), sbq[k].size(), 0);
        end
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
